// File: rtl/reg_bank.sv
// reg_bank: register file with two registered read ports, one write port and
// a hardware clear sweep that zeroes every entry one per cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   wr_en      write strobe (ignored while busy)
//   wr_addr    write address
//   wr_data    write data
//   rd_addr_a  read port A address, rd_data_a valid one cycle later
//   rd_addr_b  read port B address, rd_data_b valid one cycle later
//   clr_req    start a clear sweep (honoured only in IDLE)
//   busy       high while the sweep is running (exactly DEPTH cycles)
//   clr_done   one-cycle pulse after the last entry has been cleared
//
// Build option
//   REG_BANK_BYPASS_EN  defined: a read of the address being written in the
//                       same cycle returns the new data (write-first).
//                       undefined: it returns the old contents (read-first).
//
// State  | meaning
// IDLE   | user writes allowed, waiting for clr_req
// SWEEP  | clearing entry[cnt] each cycle, user writes dropped
// DONE   | sweep finished, clr_done pulse, back to IDLE next cycle

module reg_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(DEPTH)-1:0]     wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0]     rd_addr_a,
    output logic [WIDTH-1:0]             rd_data_a,
    input  logic [$clog2(DEPTH)-1:0]     rd_addr_b,
    output logic [WIDTH-1:0]             rd_data_b,
    input  logic                         clr_req,
    output logic                         busy,
    output logic                         clr_done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [WIDTH-1:0]   rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0]   rd_data_b_q, rd_data_b_d;
    logic               busy_q, busy_d;
    logic               clr_done_q, clr_done_d;

    // Effective write of this cycle: either the user write or the sweep write.
    logic               we;
    logic [AW-1:0]      wa;
    logic [WIDTH-1:0]   wd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        we      = 1'b0;
        wa      = wr_addr;
        wd      = wr_data;

        case (state_q)
            IDLE: begin
                // A write on the same edge as clr_req still lands; the sweep
                // clears it later.
                we = wr_en;
                if (clr_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                we = 1'b1;
                wa = cnt_q;
                wd = '0;
                // Counter parks at DEPTH-1 rather than wrapping.
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            DONE: begin
                // busy is already low here, so user writes are accepted.
                we      = wr_en;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (we) begin
            mem_d[wa] = wd;
        end

        rd_data_a_d = mem_q[rd_addr_a];
        rd_data_b_d = mem_q[rd_addr_b];
`ifdef REG_BANK_BYPASS_EN
        if (we && (wa == rd_addr_a)) begin
            rd_data_a_d = wd;
        end
        if (we && (wa == rd_addr_b)) begin
            rd_data_b_d = wd;
        end
`endif

        busy_d     = (state_d == SWEEP);
        clr_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_q       <= '{default: '0};
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            busy_q      <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_q       <= mem_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            busy_q      <= busy_d;
            clr_done_q  <= clr_done_d;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign busy      = busy_q;
    assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;

`ifdef REG_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;

    // Default instance: WIDTH 16, DEPTH 8
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_b;
    logic        clr_req;
    logic        busy;
    logic        clr_done;

    // Wide instance: WIDTH 8, DEPTH 32
    logic        w_wr_en;
    logic [4:0]  w_wr_addr;
    logic [7:0]  w_wr_data;
    logic [4:0]  w_rd_addr_a;
    logic [7:0]  w_rd_data_a;
    logic [4:0]  w_rd_addr_b;
    logic [7:0]  w_rd_data_b;
    logic        w_clr_req;
    logic        w_busy;
    logic        w_clr_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] model [8];

    reg_bank #(.WIDTH(16), .DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .clr_req   (clr_req),
        .busy      (busy),
        .clr_done  (clr_done)
    );

    reg_bank #(.WIDTH(8), .DEPTH(32)) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (w_wr_en),
        .wr_addr   (w_wr_addr),
        .wr_data   (w_wr_data),
        .rd_addr_a (w_rd_addr_a),
        .rd_data_a (w_rd_data_a),
        .rd_addr_b (w_rd_addr_b),
        .rd_data_b (w_rd_data_b),
        .clr_req   (w_clr_req),
        .busy      (w_busy),
        .clr_done  (w_clr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill();
        for (int i = 0; i < 8; i++) begin
            wr_en    = 1'b1;
            wr_addr  = 3'(i);
            wr_data  = 16'($urandom) | 16'h0001;
            model[i] = wr_data;
            tick();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_a, exp_b, old6;
        int busy_cnt, done_cnt, done_idx;

        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; clr_req = 1'b0;
        w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
        w_rd_addr_a = '0; w_rd_addr_b = '0; w_clr_req = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = '0;

        tick(); tick();
        check("rst_rd_a", 64'(rd_data_a), 64'h0);
        check("rst_rd_b", 64'(rd_data_b), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(clr_done), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic write then read
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234; model[3] = 16'h1234;
        tick();
        wr_en = 1'b0; rd_addr_a = 3'd3;
        tick();
        check("wr3_rd_a", 64'(rd_data_a), 64'h1234);

        // Same-edge write and read of one address
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF; rd_addr_b = 3'd5;
        exp_b = BYP ? 16'hBEEF : model[5];
        model[5] = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        check("same_edge_b", 64'(rd_data_b), 64'(exp_b));

        // Random traffic against the array model
        for (int k = 0; k < 40; k++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = 3'($urandom_range(0, 7));
            wr_data   = 16'($urandom);
            rd_addr_a = 3'($urandom_range(0, 7));
            rd_addr_b = 3'($urandom_range(0, 7));
            exp_a = (BYP && wr_en && wr_addr == rd_addr_a) ? wr_data : model[rd_addr_a];
            exp_b = (BYP && wr_en && wr_addr == rd_addr_b) ? wr_data : model[rd_addr_b];
            if (wr_en) model[wr_addr] = wr_data;
            tick();
            check("rand_a", 64'(rd_data_a), 64'(exp_a));
            check("rand_b", 64'(rd_data_b), 64'(exp_b));
        end
        wr_en = 1'b0;

        // Full sweep with a held write to entry 7 and stray clear requests
        fill();
        old6 = model[6];
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hFFFF;
        rd_addr_a = 3'd6; rd_addr_b = 3'd0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_idx = -1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick();
            if (busy) busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                done_idx = i;
                wr_en    = 1'b0;
                clr_req  = 1'b1;
            end else begin
                clr_req = 1'b0;
            end
            if (i == 4) clr_req = 1'b1;
            if (i == 2) begin
                check("mid_sweep_old", 64'(rd_data_a), 64'(old6));
                check("mid_sweep_zero", 64'(rd_data_b), 64'h0);
            end
        end
        clr_req = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = '0;
        check("sweep_busy_cycles", 64'(busy_cnt), 64'd8);
        check("sweep_done_pulses", 64'(done_cnt), 64'd1);
        check("sweep_done_index", 64'(done_idx), 64'd8);
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(7 - i);
            tick();
            check("post_sweep_a", 64'(rd_data_a), 64'(model[i]));
            check("post_sweep_b", 64'(rd_data_b), 64'(model[7 - i]));
        end

        // Reset in the middle of a sweep
        fill();
        rd_addr_a = 3'd5; rd_addr_b = 3'd6;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_done", 64'(clr_done), 64'h0);
        check("abort_rd_a", 64'(rd_data_a), 64'h0);
        check("abort_rd_b", 64'(rd_data_b), 64'h0);
        for (int i = 0; i < 8; i++) model[i] = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (clr_done) done_cnt++;
        end
        check("abort_no_busy", 64'(busy_cnt), 64'd0);
        check("abort_no_pulse", 64'(done_cnt), 64'd0);
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            tick();
            check("abort_cleared", 64'(rd_data_a), 64'(model[i]));
        end
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h5A5A; model[2] = 16'h5A5A;
        tick();
        wr_en = 1'b0; rd_addr_a = 3'd2;
        tick();
        check("abort_fresh_write", 64'(rd_data_a), 64'(model[2]));

        // WIDTH 8 / DEPTH 32 instance
        w_wr_en = 1'b1; w_wr_addr = 5'd31; w_wr_data = 8'hA5;
        tick();
        w_wr_en = 1'b0; w_rd_addr_a = 5'd31; w_rd_addr_b = 5'd31;
        tick();
        check("w_rd31_a", 64'(w_rd_data_a), 64'hA5);
        check("w_rd31_b", 64'(w_rd_data_b), 64'hA5);
        w_clr_req = 1'b1;
        tick();
        w_clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (i > 0) tick();
            if (w_busy) busy_cnt++;
            if (w_clr_done) done_cnt++;
        end
        check("w_busy_cycles", 64'(busy_cnt), 64'd32);
        check("w_done_pulses", 64'(done_cnt), 64'd1);
        tick();
        check("w_rd31_cleared", 64'(w_rd_data_a), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
